// File: rtl/fifo_skid_buf.sv
// Two-entry in-order buffer between the FIFO read port and the stream output.
// 1-bit head/tail pointers wrap modulo 2; occ tracks how many entries hold words.
module fifo_skid_buf #(
  parameter int dwidth = 8
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              wr,
  input  logic [dwidth-1:0] wdata,
  input  logic              rd,
  output logic [dwidth-1:0] rdata,
  output logic [1:0]        occ
);

  logic [dwidth-1:0] mem [2];
  logic              head;
  logic              tail;

  // Entries are cleared on reset so the stream output reads zero while idle.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      mem[0] <= '0;
      mem[1] <= '0;
      head   <= 1'b0;
      tail   <= 1'b0;
      occ    <= 2'd0;
    end else begin
      if (wr) begin
        mem[tail] <= wdata;
        tail      <= ~tail;
      end
      if (rd) begin
        head <= ~head;
      end
      occ <= occ + {1'b0, wr} - {1'b0, rd};
    end
  end

  assign rdata = mem[head];

endmodule

// File: rtl/fifo_stream_reader.sv
// Reads a synchronous FIFO and presents its words on a valid/ready stream.
// A credit check over buffered plus in-flight words lets the reader sustain one word per clock.
module fifo_stream_reader #(
  parameter int dwidth = 8,
  parameter int cwidth = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              fifo_empty,
  input  logic [dwidth-1:0] fifo_data,
  output logic              fifo_rd_en,
  output logic              m_valid,
  input  logic              m_ready,
  output logic [dwidth-1:0] m_data,
  output logic [cwidth-1:0] m_count,
  output logic              busy
);

  logic [1:0] occ;
  logic       infl;
  logic       pop;
  logic [2:0] used;

  assign m_valid = (occ != 2'd0);
  assign pop     = m_valid && m_ready;

  // Slots that will still be claimed after this cycle's pop; m_ready feeds the
  // read strobe combinationally so a pop can free room for a same-cycle read.
  assign used       = {1'b0, occ} + {2'b00, infl} - {2'b00, pop};
  assign fifo_rd_en = !rst && !fifo_empty && (used < 3'd2);
  assign busy       = m_valid || infl;

  fifo_skid_buf #(
    .dwidth(dwidth)
  ) u_buf (
    .clk  (clk),
    .rst  (rst),
    .wr   (infl),
    .wdata(fifo_data),
    .rd   (pop),
    .rdata(m_data),
    .occ  (occ)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      infl    <= 1'b0;
      m_count <= '0;
    end else begin
      infl <= fifo_rd_en;
      if (pop) begin
        m_count <= m_count + cwidth'(1);
      end
    end
  end

`ifndef SYNTHESIS
  a_credit: assert property (@(posedge clk) disable iff (rst)
    ({1'b0, occ} + {2'b00, infl}) <= 3'd2);
`endif

endmodule

// File: tb/tb_fifo_stream_reader.sv
// Randomized bench: a queue-based FIFO model feeds the reader, and a word-count
// reference model predicts valid, data order, read strobe, busy and the delivered count.
module tb_fifo_stream_reader;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        fifo_empty = 1'b1;
  logic [7:0]  fifo_data = 8'h00;
  logic        fifo_rd_en;
  logic        m_valid;
  logic        m_ready = 1'b0;
  logic [7:0]  m_data;
  logic [15:0] m_count;
  logic        busy;

  always #5 clk = ~clk;

  fifo_stream_reader #(
    .dwidth(8),
    .cwidth(16)
  ) dut (
    .clk       (clk),
    .rst       (rst),
    .fifo_empty(fifo_empty),
    .fifo_data (fifo_data),
    .fifo_rd_en(fifo_rd_en),
    .m_valid   (m_valid),
    .m_ready   (m_ready),
    .m_data    (m_data),
    .m_count   (m_count),
    .busy      (busy)
  );

  int n_checks = 0;
  int n_errors = 0;

  // fq: words still inside the FIFO; sb: words read out of it, not yet delivered.
  logic [7:0] fq[$];
  logic [7:0] sb[$];
  int  issued;
  int  captured;
  int  delivered;
  bit  prev_rd;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic model_reset();
    fq.delete();
    sb.delete();
    issued    = 0;
    captured  = 0;
    delivered = 0;
    prev_rd   = 1'b0;
  endtask

  // One clock: drive, check settled outputs at negedge, then advance the models.
  task automatic cycle(input bit rdy);
    bit rd;
    bit pop;
    bit exp_valid;
    int outst;
    m_ready    = rdy;
    fifo_empty = (fq.size() == 0);
    @(negedge clk);
    exp_valid = (captured > delivered);
    pop       = exp_valid && rdy;
    outst     = issued - delivered;
    chk("m_valid", 32'(m_valid), 32'(exp_valid));
    if (exp_valid) chk("m_data", 32'(m_data), 32'(sb[0]));
    chk("fifo_rd_en", 32'(fifo_rd_en), 32'(!fifo_empty && ((outst - int'(pop)) < 2)));
    chk("busy", 32'(busy), 32'(outst > 0));
    chk("m_count", 32'(m_count), 32'(delivered % 65536));
    rd = fifo_rd_en;
    @(posedge clk);
    #1;
    if (prev_rd) captured++;
    if (pop) begin
      void'(sb.pop_front());
      delivered++;
    end
    if (rd && fq.size() > 0) begin
      fifo_data = fq.pop_front();
      sb.push_back(fifo_data);
      issued++;
    end
    prev_rd = rd;
    fifo_empty = (fq.size() == 0);
  endtask

  task automatic drain(input string tag, input int target, input int budget, input bit rnd);
    int n = 0;
    while (delivered < target && n < budget) begin
      cycle(rnd ? 1'($urandom_range(0, 1)) : 1'b1);
      n++;
    end
    chk(tag, 32'(delivered), 32'(target));
  endtask

  initial begin
    int base;
    int iss0;

    // Reset holds the read strobe low even with a non-empty FIFO.
    model_reset();
    for (int i = 1; i <= 16; i++) fq.push_back(8'(i));
    fifo_empty = 1'b0;
    rst = 1'b1;
    #1;
    chk("rst_rd_en", 32'(fifo_rd_en), 32'(0));
    chk("rst_valid", 32'(m_valid), 32'(0));
    chk("rst_count", 32'(m_count), 32'(0));
    chk("rst_busy", 32'(busy), 32'(0));
    chk("rst_data", 32'(m_data), 32'(0));
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b0;

    // Streaming at full rate: 16 words in 18 clocks from release.
    repeat (18) cycle(1'b1);
    chk("stream_count", 32'(m_count), 32'(16));
    chk("stream_busy", 32'(busy), 32'(0));

    // Random backpressure over 32 random words.
    base = delivered;
    for (int i = 0; i < 32; i++) fq.push_back(8'($urandom));
    drain("bp_drain", base + 32, 400, 1'b1);

    // Stall at full buffer: exactly two reads, head word held.
    repeat (3) cycle(1'b1);
    fq.push_back(8'hA5);
    fq.push_back(8'h5A);
    fq.push_back(8'h11);
    fq.push_back(8'h22);
    iss0 = issued;
    repeat (10) cycle(1'b0);
    chk("stall_reads", 32'(issued - iss0), 32'(2));
    chk("stall_data", 32'(m_data), 32'(8'hA5));
    base = delivered;
    repeat (2) cycle(1'b1);
    chk("stall_b2b", 32'(delivered - base), 32'(2));
    drain("stall_drain", base + 4, 50, 1'b0);

    // Single word then empty.
    repeat (3) cycle(1'b1);
    fq.push_back(8'h3C);
    drain("single", delivered + 1, 20, 1'b0);
    repeat (2) cycle(1'b1);
    chk("empty_valid", 32'(m_valid), 32'(0));
    chk("empty_busy", 32'(busy), 32'(0));
    chk("empty_rd_en", 32'(fifo_rd_en), 32'(0));

    // Mid-stream asynchronous reset with a full buffer.
    for (int i = 0; i < 4; i++) fq.push_back(8'(8'hC0 + i));
    repeat (5) cycle(1'b0);
    chk("pre_rst_full", 32'(issued - delivered), 32'(2));
    #2;
    rst = 1'b1;
    #1;
    chk("arst_valid", 32'(m_valid), 32'(0));
    chk("arst_busy", 32'(busy), 32'(0));
    chk("arst_count", 32'(m_count), 32'(0));
    chk("arst_rd_en", 32'(fifo_rd_en), 32'(0));
    model_reset();
    fifo_empty = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    fq.push_back(8'h55);
    fq.push_back(8'h66);
    drain("post_rst", 2, 20, 1'b0);
    repeat (2) cycle(1'b1);
    chk("post_rst_count", 32'(m_count), 32'(2));
    chk("post_rst_busy", 32'(busy), 32'(0));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
